// File: rtl/pulse_stretch_pkg.sv
// -----------------------------------------------------------------------------
// pulse_stretch_pkg
// Shared definitions for the pulse stretcher: FSM state encoding and the
// helper that sizes the interval timer.
// Optional feature macro used by the design: PULSE_STRETCH_RETRIG_EN.
// -----------------------------------------------------------------------------
package pulse_stretch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HOLD = 2'b01,
    GAP  = 2'b10
  } state_e;

  // Timer width: enough bits for the larger of the two reload values.
  // A count of 1 would give $clog2(1) = 0, so the width never drops below 1.
  function automatic int unsigned timer_width(input int unsigned hold_cnt,
                                              input int unsigned gap_cnt);
    int unsigned max_cnt;
    max_cnt = (hold_cnt > gap_cnt) ? hold_cnt : gap_cnt;
    if (max_cnt > 32'd1) begin
      return $clog2(max_cnt);
    end else begin
      return 32'd1;
    end
  endfunction

endpackage

// File: rtl/pulse_stretcher_interval_timer.sv
// -----------------------------------------------------------------------------
// interval_timer
// Loadable down-counter used to time the HOLD and GAP intervals.
// The counter decrements every cycle while non-zero and stops at zero
// (no wrap-around).
// Ports:
//   clk      - system clock, rising edge
//   rst      - asynchronous active-low reset (count cleared to 0)
//   load     - load load_val this cycle (takes priority over counting)
//   load_val - value to load
//   zero     - high while the count is 0
// -----------------------------------------------------------------------------
module interval_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
  localparam logic [W-1:0] CNT_ONE  = W'(1);

  logic [W-1:0] count_q;

  // Count register: load, decrement toward zero, or hold at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= CNT_ZERO;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != CNT_ZERO) begin
      count_q <= count_q - CNT_ONE;
    end else begin
      count_q <= count_q;
    end
  end

  assign zero = (count_q == CNT_ZERO);

endmodule

// File: rtl/pulse_stretcher.sv
// -----------------------------------------------------------------------------
// pulse_stretcher
// Turns single-cycle trigger pulses into fixed-length output high intervals
// (HOLD_CNT cycles) each followed by a low guard interval (GAP_CNT cycles).
// Triggers arriving during an interval are queued in a saturating counter and
// replayed in order; a dropped trigger sets the sticky overflow flag.
// Optional feature macro: PULSE_STRETCH_RETRIG_EN -- when defined, a trigger
// during HOLD restarts the high interval instead of being queued.
// Ports:
//   clk       - system clock, rising edge
//   rst       - asynchronous active-low reset
//   trig      - single-cycle request pulse
//   out_level - stretched output level (registered)
//   busy      - high whenever the FSM is not IDLE (registered)
//   pending   - queued triggers not yet launched (registered)
//   overflow  - sticky, set when a trigger is dropped (registered)
// -----------------------------------------------------------------------------
module pulse_stretcher
  import pulse_stretch_pkg::*;
#(
  parameter int unsigned HOLD_CNT = 1_500_000,
  parameter int unsigned GAP_CNT  = 500_000,
  parameter int unsigned QUEUE_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               trig,
  output logic               out_level,
  output logic               busy,
  output logic [QUEUE_W-1:0] pending,
  output logic               overflow
);

  localparam int unsigned        TW        = timer_width(HOLD_CNT, GAP_CNT);
  localparam logic [TW-1:0]      HOLD_LOAD = TW'(HOLD_CNT - 32'd1);
  localparam logic [TW-1:0]      GAP_LOAD  = TW'(GAP_CNT - 32'd1);
  localparam logic [TW-1:0]      TMR_ZERO  = {TW{1'b0}};
  localparam logic [QUEUE_W-1:0] PEND_ZERO = {QUEUE_W{1'b0}};
  localparam logic [QUEUE_W-1:0] PEND_ONE  = QUEUE_W'(1);
  localparam logic [QUEUE_W-1:0] PEND_MAX  = {QUEUE_W{1'b1}};

  state_e             state_q, state_d;
  logic               out_level_q, out_level_d;
  logic               busy_q, busy_d;
  logic [QUEUE_W-1:0] pending_q, pending_d;
  logic               overflow_q, overflow_d;

  logic               tmr_load_s;
  logic [TW-1:0]      tmr_val_s;
  logic               tmr_zero_s;
  logic               inc_s;
  logic               dec_s;

  interval_timer #(
    .W (TW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .zero     (tmr_zero_s)
  );

  // Next-state logic plus timer load and queue increment/decrement requests.
  always_comb begin
    state_d    = state_q;
    tmr_load_s = 1'b0;
    tmr_val_s  = TMR_ZERO;
    inc_s      = 1'b0;
    dec_s      = 1'b0;
    case (state_q)
      IDLE: begin
        if (trig) begin
          state_d    = HOLD;
          tmr_load_s = 1'b1;
          tmr_val_s  = HOLD_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
`ifdef PULSE_STRETCH_RETRIG_EN
        // Retrigger restarts the high interval, even on its final cycle.
        if (trig) begin
          tmr_load_s = 1'b1;
          tmr_val_s  = HOLD_LOAD;
        end else if (tmr_zero_s) begin
          state_d    = GAP;
          tmr_load_s = 1'b1;
          tmr_val_s  = GAP_LOAD;
        end else begin
          state_d = HOLD;
        end
`else
        inc_s = trig;
        if (tmr_zero_s) begin
          state_d    = GAP;
          tmr_load_s = 1'b1;
          tmr_val_s  = GAP_LOAD;
        end else begin
          state_d = HOLD;
        end
`endif
      end
      GAP: begin
        if (tmr_zero_s) begin
          if (pending_q != PEND_ZERO) begin
            // Launch the oldest queued trigger; a new trig still queues.
            state_d    = HOLD;
            tmr_load_s = 1'b1;
            tmr_val_s  = HOLD_LOAD;
            dec_s      = 1'b1;
            inc_s      = trig;
          end else if (trig) begin
            // Empty queue: this trigger launches directly, never counted.
            state_d    = HOLD;
            tmr_load_s = 1'b1;
            tmr_val_s  = HOLD_LOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          inc_s   = trig;
          state_d = GAP;
        end
      end
      default: begin
        state_d    = IDLE;
        tmr_load_s = 1'b1;
        tmr_val_s  = TMR_ZERO;
      end
    endcase
  end

  // Saturating pending counter, sticky overflow and Moore output decode.
  always_comb begin
    pending_d  = pending_q;
    overflow_d = overflow_q;
    if (inc_s && !dec_s) begin
      if (pending_q == PEND_MAX) begin
        overflow_d = 1'b1;
      end else begin
        pending_d = pending_q + PEND_ONE;
      end
    end else if (dec_s && !inc_s) begin
      pending_d = pending_q - PEND_ONE;
    end else begin
      pending_d = pending_q;
    end
    // Decoded from the next state so the registered outputs line up with it.
    out_level_d = (state_d == HOLD);
    busy_d      = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      out_level_q <= 1'b0;
      busy_q      <= 1'b0;
      pending_q   <= PEND_ZERO;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_level_q <= out_level_d;
      busy_q      <= busy_d;
      pending_q   <= pending_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_level = out_level_q;
  assign busy      = busy_q;
  assign pending   = pending_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// -----------------------------------------------------------------------------
// tb_pulse_stretcher
// Directed, table-driven bench for pulse_stretcher with HOLD_CNT=4, GAP_CNT=2,
// QUEUE_W=2. Each table row gives the trig value sampled at one rising edge
// and the outputs expected just after that edge. Honours
// PULSE_STRETCH_RETRIG_EN for the retrigger scenario.
// -----------------------------------------------------------------------------
module tb_pulse_stretcher;

  typedef struct {
    logic       trig;
    logic       out_level;
    logic       busy;
    logic [1:0] pending;
    logic       overflow;
    string      name;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       trig;
  logic       out_level;
  logic       busy;
  logic [1:0] pending;
  logic       overflow;

  int   total;
  int   bad;
  int   rises;
  logic prev_out;
  vec_t vecs[$];

  pulse_stretcher #(
    .HOLD_CNT (4),
    .GAP_CNT  (2),
    .QUEUE_W  (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .trig      (trig),
    .out_level (out_level),
    .busy      (busy),
    .pending   (pending),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input int n, input logic t, input logic o, input logic b,
                     input logic [1:0] p, input logic ov, input string nm);
    for (int i = 0; i < n; i++) begin
      vecs.push_back('{t, o, b, p, ov, nm});
    end
  endtask

  task automatic check(input string nm, input logic [4:0] act, input logic [4:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got {out,busy,pend,ovf}=%b expected %b at %0t", nm, act, exp_v, $time);
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rises    = 0;
    prev_out = 1'b0;
    trig     = 1'b0;
    rst      = 1'b0;

    // Reset state (asynchronous, before any clock edge).
    #1;
    check("reset", {out_level, busy, pending, overflow}, 5'b00000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Single trigger: high 4, low 2, then idle.
    add(1, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, "single");
    add(3, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, "single");
    add(2, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, "single");
    add(2, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, "single");
    // Trigger on the GAP-final cycle with an empty queue launches directly.
    add(1, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, "gapfinal");
    add(3, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, "gapfinal");
    add(2, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, "gapfinal");
    add(1, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, "gapfinal");
    add(3, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, "gapfinal");
    add(2, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, "gapfinal");
    add(1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, "gapfinal");
    // Three back-to-back triggers: pulses 6 cycles apart, queue drains.
    add(1, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, "triple");
    add(1, 1'b1, 1'b1, 1'b1, 2'd1, 1'b0, "triple");
    add(1, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, "triple");
    add(1, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, "triple");
    add(2, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, "triple");
    add(4, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, "triple");
    add(2, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, "triple");
    add(4, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, "triple");
    add(2, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, "triple");
    add(1, 1'b0, 1'b0, 0, 2'd0, 1'b0, "triple");
`ifdef PULSE_STRETCH_RETRIG_EN
    // Trigger during HOLD extends the pulse: high for 6 cycles, one pulse.
    add(1, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, "retrig");
    add(1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, "retrig");
    add(1, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, "retrig");
    add(3, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, "retrig");
    add(2, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, "retrig");
    add(1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, "retrig");
`else
    // Trigger during HOLD queues: two separate pulses.
    add(1, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, "retrig");
    add(1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, "retrig");
    add(1, 1'b1, 1'b1, 1'b1, 2'd1, 1'b0, "retrig");
    add(1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, "retrig");
    add(2, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, "retrig");
    add(4, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, "retrig");
    add(2, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, "retrig");
    add(1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, "retrig");
`endif
    // Five triggers: one launches, three queue, the fifth is dropped.
    add(1, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, "ovf");
    add(1, 1'b1, 1'b1, 1'b1, 2'd1, 1'b0, "ovf");
    add(1, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, "ovf");
    add(1, 1'b1, 1'b1, 1'b1, 2'd3, 1'b0, "ovf");
    add(1, 1'b1, 1'b0, 1'b1, 2'd3, 1'b1, "ovf");
    add(1, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1, "ovf");
    add(4, 1'b0, 1'b1, 1'b1, 2'd2, 1'b1, "ovf");
    add(2, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, "ovf");
    add(4, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, "ovf");
    add(2, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, "ovf");
    add(4, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1, "ovf");
    add(2, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, "ovf");
    add(2, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, "ovf");

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      trig = vecs[i].trig;
      @(posedge clk);
      #1;
      check(vecs[i].name, {out_level, busy, pending, overflow},
            {vecs[i].out_level, vecs[i].busy, vecs[i].pending, vecs[i].overflow});
      if (vecs[i].name == "ovf" && out_level && !prev_out) begin
        rises++;
      end
      prev_out = out_level;
    end
    @(negedge clk);
    trig = 1'b0;

    // Exactly four pulses from five triggers with a depth-3 queue.
    total++;
    if (rises != 4) begin
      bad++;
      $display("FAIL ovf_pulses: got %0d pulses expected 4", rises);
    end

    // Reset in mid-HOLD with two queued triggers aborts and discards the queue.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      trig = 1'b1;
      @(posedge clk);
    end
    #1;
    check("pre_rst", {out_level, busy, pending, overflow}, 5'b11101);
    @(negedge clk);
    trig = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst", {out_level, busy, pending, overflow}, 5'b00000);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      check("post_rst", {out_level, busy, pending, overflow}, 5'b00000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pulse_stretcher.md
Name: pulse_stretcher

Overview:
- Output-side counterpart of the switch debouncer. Turns internal single-cycle pulses into clean, human-visible output levels, for example on an LED, buzzer or relay.
- Each accepted trigger produces exactly one high interval of fixed length, followed by a mandatory low guard interval.
- Triggers that arrive while an interval is in progress are counted and replayed in order, so no events are lost up to the queue depth.
- Sits between control logic (one-shot producers) and board outputs; runs on the 50 MHz system clock.

Parameters:
- HOLD_CNT, 1_500_000: high-time in clk cycles (30 ms at 50 MHz); must be at least 1.
- GAP_CNT, 500_000: low guard time in clk cycles (10 ms); must be at least 1.
- QUEUE_W, 4: width of the pending-trigger counter; maximum pending = 2^QUEUE_W - 1.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: asynchronous active-low reset.
- trig, input, 1: single-cycle request pulse, synchronous to clk.
- out_level, output, 1: stretched output level, registered.
- busy, output, 1: high when state is not IDLE.
- pending, output, QUEUE_W: number of queued, not-yet-launched triggers.
- overflow, output, 1: sticky; set when a trigger is dropped.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, timer=0, out_level=0, busy=0, pending=0, overflow=0. Reset mid-interval aborts immediately and discards the queue.
- All outputs are registered (Moore); no combinational path from trig to any output.
- States:
  - IDLE: out_level=0. If trig=1, go to HOLD, load timer with HOLD_CNT-1, and leave pending unchanged.
  - HOLD: out_level=1. Timer decrements each cycle. When timer=0, go to GAP and load timer with GAP_CNT-1.
  - GAP: out_level=0. Timer decrements each cycle. When timer=0, the launch condition is pending>0 or trig=1:
    - If launch, go to HOLD and reload HOLD_CNT-1.
    - Otherwise go to IDLE.
- Latency: trig sampled at edge k gives out_level=1 over edges k through k+HOLD_CNT-1 (exactly HOLD_CNT cycles), then 0 for exactly GAP_CNT cycles. A queued trigger produces its next rising out_level at edge k+HOLD_CNT+GAP_CNT.
- Queue accounting, applied every cycle:
  - pending_next = pending + inc - dec.
  - inc = trig while in HOLD or GAP, excluding the GAP-final cycle when pending=0 (in that case trig launches directly).
  - dec = 1 on a GAP-final launch with pending>0.
  - Simultaneous inc and dec leave pending unchanged.
- Saturation: if inc=1 and pending=2^QUEUE_W-1, pending holds its value, the trigger is dropped, and overflow is set to 1. overflow clears only on reset.
- Widths: timer width is $clog2 of the larger of HOLD_CNT and GAP_CNT. All arithmetic is unsigned; no wrap-around anywhere.
- Illegal state encodings go to IDLE with out_level=0.

Optional Feature:
- PULSE_STRETCH_RETRIG_EN defined:
  - trig during HOLD reloads the timer with HOLD_CNT-1, extending the current pulse, and does not increment pending.
  - trig during GAP queues as normal.
- Not defined: trig during HOLD queues, per the accounting above.

Decomposition:
- Shared package pulse_stretch_pkg holds:
  - state encoding constants IDLE=2'b00, HOLD=2'b01, GAP=2'b10;
  - a helper function computing the timer width.
- One sub-module, interval_timer:
  - loadable down-counter;
  - ports clk, rst, load, load_val, zero.
- The FSM and queue stay in pulse_stretcher.

Test Plan (HOLD_CNT=4, GAP_CNT=2, QUEUE_W=2):
- Single trig at cycle 10 -> out_level high cycles 10-13, low 14-15, busy low from cycle 16, pending=0.
- Triggers at cycles 10, 11 and 12 -> three pulses rising at 10, 16 and 22; pending goes 1, 2, then 1 at 16, then 0 at 22.
- Five triggers during the first HOLD -> pending saturates at 3, overflow=1, exactly four pulses total.
- trig in the GAP-final cycle (15) with pending=0 -> HOLD resumes at 16, pending stays 0.
- rst asserted low during HOLD at cycle 12 with pending=2 -> out_level=0 and pending=0 immediately; after release, IDLE with no replay.
- With PULSE_STRETCH_RETRIG_EN, triggers at 10 and 12 -> out_level high cycles 10-15, pending=0, single pulse.
